mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage that consumes the EX/MEM pipeline register outputs and drives the MEM/WB register. It performs load/store transfers over a req/ack data-memory handshake, stalling upstream stages while a transfer is outstanding. It resolves branches for the PC mux and registers results into the MEM/WB register for write-back.

## Interface
- TIMEOUT_CYCLES, 16: ACCESS cycles without ack before abort (only with MEM_TIMEOUT_EN)
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- WB  in  2  [1]=RegWrite, [0]=MemtoReg (from EX/MEM register)
- M  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
- jump_address  in  8  branch target
- ALU_status  in  8  [0]=zero flag; other bits unused
- ALU_result  in  32  memory address / pass-through result
- write_data  in  32  store data
- RegDst_address  in  5  destination register
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1=write, 0=read; valid while dmem_req
- dmem_addr  out  32  equals ALU_result
- dmem_wdata  out  32  equals write_data
- dmem_ack  in  1  one-cycle completion strobe
- dmem_rdata  in  32  read data, valid with dmem_ack
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- pc_src  out  1  take branch
- branch_target  out  8  equals jump_address
- _WB  out  2  MEM/WB control
- _read_data  out  32  loaded data
- _ALU_result  out  32  forwarded result
- _RegDst_address  out  5  forwarded destination
- dmem_err  out  1  sticky timeout flag

## Operation
- mem_op = M[1] | M[0]; both set: write priority, no data captured (_read_data = 0).
- FSM states IDLE, ACCESS.
- IDLE, !mem_op: stall=0; MEM/WB register loads inputs (_read_data=0) each edge.
- IDLE, mem_op: stall=1; next state ACCESS; dmem_req set to 1 on the same edge; MEM/WB loads bubble (all fields 0).
- ACCESS, !dmem_ack: stall=1, dmem_req held 1, addr/we/wdata stable; MEM/WB loads bubble.
- ACCESS, dmem_ack: stall=0 combinationally; on edge MEM/WB loads inputs with _read_data=dmem_rdata (reads) or 0 (writes); dmem_req cleared; next state IDLE.
- Inputs are held stable by upstream during stall; the block does not re-sample them.
- pc_src = M[2] & ALU_status[0] & !stall, combinational; branch_target = jump_address.
- dmem_ack outside ACCESS is ignored.

## Timing
- Reset (async, any state, including mid-transfer): state IDLE, dmem_req=0, dmem_err=0, all MEM/WB outputs 0; stall then follows combinational rules from inputs.
- Non-memory instruction: 1-cycle latency to MEM/WB outputs.
- Memory instruction: latency 2 + N cycles, N = cycles dmem_ack arrives after dmem_req rises (ack in first ACCESS cycle gives 2).
- Back-to-back memory ops: each returns to IDLE for one cycle before the next req; dmem_req low for exactly one cycle between them.
- stall asserted from first detect cycle through the cycle before ack; deasserted in the ack cycle.

## Configuration
- MEM_TIMEOUT_EN defined: wait counter reset on entry to ACCESS. TIMEOUT_CYCLES cycles in ACCESS without ack → drop dmem_req, set dmem_err (sticky until reset), load MEM/WB with _WB forced 0 (squashed), return IDLE, stall released that cycle.
- Undefined: no counter, unbounded wait; dmem_err tied 0.

## Structure
- Package mem_stage_pkg: state enum (IDLE, ACCESS), bit-index constants for M (BRANCH=2, MEMREAD=1, MEMWRITE=0) and WB (REGWRITE=1, MEMTOREG=0).
- One sub-module, mem_wb_reg: async-reset MEM/WB register with load and bubble controls. FSM, handshake, and branch logic live in mem_stage.

## Test plan
- ALU op (M=000, WB=10, ALU_result=0x0000_0042, RegDst=5) → next edge _WB=10, _ALU_result=0x42, _RegDst_address=5, stall never high.
- Load (M=010, addr 0x100), ack 3 cycles after req with rdata 0xCAFE_F00D → stall high 4 cycles, then _read_data=0xCAFE_F00D, _WB=11.
- Store (M=001, addr 0x104, wdata 0x1234_5678), immediate ack → dmem_we=1 with stable addr/wdata while req; 2-cycle latency; _read_data=0.
- Branch (M=100, ALU_status[0]=1, jump_address=0x3C) → pc_src=1, branch_target=0x3C; with ALU_status[0]=0 → pc_src=0.
- rst_n pulsed low mid-ACCESS → dmem_req=0, outputs 0, state IDLE immediately; late dmem_ack ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → after 4 ACCESS cycles dmem_err=1, _WB=00, stall released; dmem_err stays 1 over later transfers.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and bit positions for the MEM pipeline stage.
package mem_stage_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int BRANCH   = 2;
   localparam int MEMREAD  = 1;
   localparam int MEMWRITE = 0;

   localparam int REGWRITE = 1;
   localparam int MEMTOREG = 0;

   typedef struct packed {
      logic [1:0]  wb;
      logic [31:0] read_data;
      logic [31:0] alu_result;
      logic [4:0]  rd;
   } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: bubble clears all fields, load captures the next entry.
module mem_wb_reg
   import mem_stage_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    load,
   input  logic    bubble,
   input  mem_wb_t d,
   output mem_wb_t q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (bubble) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory req/ack handshake, pipeline stall, branch resolve, MEM/WB feed.
// Optional access timeout with sticky error flag is enabled by defining MEM_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transfer outstanding; a memory op here raises dmem_req on the next edge
// ACCESS | dmem_req high, waiting for dmem_ack (or the timeout, when enabled)
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  WB,
   input  logic [2:0]  M,
   input  logic [7:0]  jump_address,
   input  logic [7:0]  ALU_status,
   input  logic [31:0] ALU_result,
   input  logic [31:0] write_data,
   input  logic [4:0]  RegDst_address,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        pc_src,
   output logic [7:0]  branch_target,
   output logic [1:0]  _WB,
   output logic [31:0] _read_data,
   output logic [31:0] _ALU_result,
   output logic [4:0]  _RegDst_address,
   output logic        dmem_err
);

   state_t  state;
   logic    mem_op;
   logic    start;
   logic    done_ok;
   logic    timeout_hit;
   logic    finish;
   mem_wb_t wb_d;
   mem_wb_t wb_q;
   logic    unused_status;

   assign mem_op  = M[MEMREAD] | M[MEMWRITE];
   assign start   = (state == IDLE) && mem_op;
   assign done_ok = (state == ACCESS) && dmem_ack;
   assign finish  = done_ok || timeout_hit;
   assign stall   = start || ((state == ACCESS) && !finish);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (start) begin
         state <= ACCESS;
      end else if (finish) begin
         state <= IDLE;
      end
   end

   // The request is exactly the ACCESS state flop, so it is registered and drops with the state.
   assign dmem_req   = (state == ACCESS);
   assign dmem_we    = M[MEMWRITE];
   assign dmem_addr  = ALU_result;
   assign dmem_wdata = write_data;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (start) begin
            wait_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
         end else if ((state == ACCESS) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end
         if (timeout_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign timeout_hit = (state == ACCESS) && !dmem_ack && (wait_cnt == '0);
   assign dmem_err    = err_q;
`else
   assign timeout_hit = 1'b0;
   assign dmem_err    = 1'b0;
`endif

   // Write wins when both MemRead and MemWrite are set, so no load data is captured then.
   always_comb begin
      wb_d            = '0;
      wb_d.wb         = timeout_hit ? 2'b00 : WB;
      wb_d.read_data  = (done_ok && M[MEMREAD] && !M[MEMWRITE]) ? dmem_rdata : 32'h0;
      wb_d.alu_result = ALU_result;
      wb_d.rd         = RegDst_address;
   end

   mem_wb_reg u_mem_wb_reg (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (!stall),
      .bubble (stall),
      .d      (wb_d),
      .q      (wb_q)
   );

   assign _WB             = wb_q.wb;
   assign _read_data      = wb_q.read_data;
   assign _ALU_result     = wb_q.alu_result;
   assign _RegDst_address = wb_q.rd;

   assign pc_src        = M[BRANCH] && ALU_status[0] && !stall;
   assign branch_target = jump_address;
   assign unused_status = ^ALU_status[7:1];

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load/store handshakes, branch, reset, timeout.
module tb_mem_stage;

   logic        clk;
   logic        rst_n;
   logic [1:0]  WB;
   logic [2:0]  M;
   logic [7:0]  jump_address;
   logic [7:0]  ALU_status;
   logic [31:0] ALU_result;
   logic [31:0] write_data;
   logic [4:0]  RegDst_address;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stall;
   logic        pc_src;
   logic [7:0]  branch_target;
   logic [1:0]  _WB;
   logic [31:0] _read_data;
   logic [31:0] _ALU_result;
   logic [4:0]  _RegDst_address;
   logic        dmem_err;

   int n_chk  = 0;
   int n_pass = 0;

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .WB              (WB),
      .M               (M),
      .jump_address    (jump_address),
      .ALU_status      (ALU_status),
      .ALU_result      (ALU_result),
      .write_data      (write_data),
      .RegDst_address  (RegDst_address),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .dmem_ack        (dmem_ack),
      .dmem_rdata      (dmem_rdata),
      .stall           (stall),
      .pc_src          (pc_src),
      .branch_target   (branch_target),
      ._WB             (_WB),
      ._read_data      (_read_data),
      ._ALU_result     (_ALU_result),
      ._RegDst_address (_RegDst_address),
      .dmem_err        (dmem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic drive(input logic [2:0] m, input logic [1:0] wb, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
      M              = m;
      WB             = wb;
      ALU_result     = addr;
      write_data     = wdata;
      RegDst_address = rd;
   endtask

   // Runs one memory op already on the inputs (called just after a rising edge while IDLE).
   // ack_at = ACCESS cycle (1-based) in which ack is returned; 0 means never.
   task automatic mem_txn(input int ack_at, input logic [31:0] rdata, input logic exp_we,
                          output int stall_cycles, output int lat, output int first_req);
      int acc;
      bit done;
      acc = 0; done = 0; stall_cycles = 0; lat = 0; first_req = -1;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (dmem_req) begin
            acc++;
            if (first_req < 0) first_req = c;
            chk("req_addr", dmem_addr, ALU_result);
            chk("req_wdata", dmem_wdata, write_data);
            chk("req_we", {31'b0, dmem_we}, {31'b0, exp_we});
            chk("bubble_wb", {30'b0, _WB}, 32'h0);
            if (acc == ack_at) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rdata;
            end
         end
         #1;
         if (stall) stall_cycles++;
         @(posedge clk);
         lat++;
         #1;
         dmem_ack   = 1'b0;
         dmem_rdata = 32'hA5A5_5A5A;
         if (acc > 0 && !dmem_req) done = 1;
      end
      if (!done) chk("txn_budget", 32'h0, 32'h1);
   endtask

   int sc, lat, fr;

   initial begin
      rst_n = 1'b0;
      drive(3'b000, 2'b00, 32'h0, 32'h0, 5'd0);
      ALU_status   = 8'h00;
      jump_address = 8'h00;
      dmem_ack     = 1'b0;
      dmem_rdata   = 32'h0;

      #12;
      chk("rst_req", {31'b0, dmem_req}, 32'h0);
      chk("rst_err", {31'b0, dmem_err}, 32'h0);
      chk("rst_wb", {30'b0, _WB}, 32'h0);
      chk("rst_rdata", _read_data, 32'h0);
      chk("rst_alu", _ALU_result, 32'h0);
      chk("rst_rd", {27'b0, _RegDst_address}, 32'h0);
      chk("rst_stall", {31'b0, stall}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ALU op: one-cycle pass-through, no stall
      drive(3'b000, 2'b10, 32'h0000_0042, 32'h0, 5'd5);
      @(negedge clk);
      chk("alu_stall", {31'b0, stall}, 32'h0);
      @(posedge clk); #1;
      chk("alu_wb", {30'b0, _WB}, 32'h2);
      chk("alu_result", _ALU_result, 32'h42);
      chk("alu_rd", {27'b0, _RegDst_address}, 32'd5);
      chk("alu_rdata", _read_data, 32'h0);

      // Load, ack in 4th ACCESS cycle (3 cycles after req rises)
      drive(3'b010, 2'b11, 32'h0000_0100, 32'h0, 5'd7);
      mem_txn(4, 32'hCAFE_F00D, 1'b0, sc, lat, fr);
      chk("ld_stall_cycles", sc, 4);
      chk("ld_latency", lat, 5);
      chk("ld_first_req", fr, 1);
      chk("ld_rdata", _read_data, 32'hCAFE_F00D);
      chk("ld_wb", {30'b0, _WB}, 32'h3);
      chk("ld_alu", _ALU_result, 32'h100);
      chk("ld_rd", {27'b0, _RegDst_address}, 32'd7);
      chk("ld_req_low", {31'b0, dmem_req}, 32'h0);

      // Back-to-back load: one IDLE cycle with req low before the next req
      drive(3'b010, 2'b10, 32'h0000_0200, 32'h0, 5'd8);
      mem_txn(1, 32'h5555_AAAA, 1'b0, sc, lat, fr);
      chk("b2b_gap", fr, 1);
      chk("b2b_latency", lat, 2);
      chk("b2b_stall_cycles", sc, 1);
      chk("b2b_rdata", _read_data, 32'h5555_AAAA);

      // Store with immediate ack
      drive(3'b001, 2'b00, 32'h0000_0104, 32'h1234_5678, 5'd0);
      mem_txn(1, 32'hDEAD_BEEF, 1'b1, sc, lat, fr);
      chk("st_latency", lat, 2);
      chk("st_stall_cycles", sc, 1);
      chk("st_rdata", _read_data, 32'h0);
      chk("st_alu", _ALU_result, 32'h104);

      // Read and write both set: write wins, no data captured
      drive(3'b011, 2'b01, 32'h0000_0108, 32'h0BAD_F00D, 5'd2);
      mem_txn(2, 32'h7777_7777, 1'b1, sc, lat, fr);
      chk("rw_latency", lat, 3);
      chk("rw_rdata", _read_data, 32'h0);
      chk("rw_wb", {30'b0, _WB}, 32'h1);

      // Branch
      drive(3'b100, 2'b00, 32'h0, 32'h0, 5'd0);
      ALU_status   = 8'h01;
      jump_address = 8'h3C;
      @(negedge clk);
      chk("br_taken", {31'b0, pc_src}, 32'h1);
      chk("br_target", {24'b0, branch_target}, 32'h3C);
      ALU_status = 8'hFE;
      #1;
      chk("br_not_taken", {31'b0, pc_src}, 32'h0);
      ALU_status = 8'h00;
      @(posedge clk); #1;

      // Reset during ACCESS, then a late ack is ignored
      drive(3'b010, 2'b11, 32'h0000_0300, 32'h0, 5'd9);
      @(negedge clk);
      @(negedge clk);
      chk("mid_req_high", {31'b0, dmem_req}, 32'h1);
      rst_n = 1'b0;
      drive(3'b000, 2'b10, 32'h0000_0077, 32'h0, 5'd3);
      #1;
      chk("mid_rst_req", {31'b0, dmem_req}, 32'h0);
      chk("mid_rst_wb", {30'b0, _WB}, 32'h0);
      chk("mid_rst_alu", _ALU_result, 32'h0);
      chk("mid_rst_stall", {31'b0, stall}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_stall", {31'b0, stall}, 32'h0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h0000_0BAD;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("late_ack_req", {31'b0, dmem_req}, 32'h0);
      chk("late_ack_rdata", _read_data, 32'h0);
      chk("late_ack_wb", {30'b0, _WB}, 32'h2);
      chk("late_ack_alu", _ALU_result, 32'h77);

`ifdef MEM_TIMEOUT_EN
      // No ack: abort after 4 ACCESS cycles, error stays set afterwards
      drive(3'b010, 2'b11, 32'h0000_0400, 32'h0, 5'd4);
      mem_txn(0, 32'h0, 1'b0, sc, lat, fr);
      chk("to_stall_cycles", sc, 4);
      chk("to_latency", lat, 5);
      chk("to_err", {31'b0, dmem_err}, 32'h1);
      chk("to_wb_squash", {30'b0, _WB}, 32'h0);
      drive(3'b001, 2'b00, 32'h0000_0404, 32'h1111_2222, 5'd0);
      mem_txn(1, 32'h0, 1'b1, sc, lat, fr);
      chk("to_err_sticky", {31'b0, dmem_err}, 32'h1);
      chk("to_next_latency", lat, 2);
`else
      chk("err_tied_low", {31'b0, dmem_err}, 32'h0);
`endif

      drive(3'b000, 2'b00, 32'h0, 32'h0, 5'd0);
      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
